// File: rtl/pcm_fsk_transmitter_if.sv
// pcm_fsk_transmitter_if: sample input, coded outputs and FSK line of the transmitter
interface pcm_fsk_transmitter_if;
  logic [12:0] datain;
  logic [7:0]  pcmlog;
  logic [8:0]  checked;
  logic        fskdata;
  modport master (output datain, input pcmlog, checked, fskdata);
  modport slave (input datain, output pcmlog, checked, fskdata);
endinterface

// File: rtl/pcm_fsk_transmitter.sv
// pcm_fsk_transmitter: A-law-style compressor, even-parity coder and 9-bit FSK serializer
module pcm_fsk_transmitter #(
  parameter int BIT_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  pcm_fsk_transmitter_if.slave bus
);
  localparam int PW = $clog2(BIT_CYCLES);
  logic [11:0]   m;
  logic [2:0]    seg;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sr_q, sr_d;
  logic          first_q, fsk_q, fsk_d, phase_wrap;
  assign m = bus.datain[11:0];
  always_comb begin
    seg = m[11] ? 3'd7 : m[10] ? 3'd6 : m[9] ? 3'd5 : m[8] ? 3'd4 :
          m[7] ? 3'd3 : m[6] ? 3'd2 : m[5] ? 3'd1 : 3'd0;
    bus.pcmlog = {bus.datain[12], seg, 4'(m >> (seg == 3'd0 ? 3'd1 : seg))};
    bus.checked = {bus.pcmlog, ^bus.pcmlog};
  end
  assign phase_wrap = phase_q == PW'(BIT_CYCLES - 1);
  // The first post-reset edge loads a frame without advancing phase, so bit 0 gets a full bit time
  always_comb begin
    phase_d = first_q ? '0 : phase_wrap ? '0 : phase_q + 1'b1;
    bit_d = first_q ? 4'd0 : !phase_wrap ? bit_q : bit_q == 4'd8 ? 4'd0 : bit_q + 4'd1;
    sr_d = first_q || (phase_wrap && bit_q == 4'd8) ? bus.checked : phase_wrap ? sr_q << 1 : sr_q;
    fsk_d = sr_d[8] ? phase_d[1] : phase_d[2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      first_q <= 1'b1;
      fsk_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      first_q <= 1'b0;
      fsk_q   <= fsk_d;
    end
  end
  assign bus.fskdata = fsk_q;
endmodule

// File: tb/tb_pcm_fsk_transmitter.sv
// tb_pcm_fsk_transmitter: directed checks of compression, parity coding and FSK framing
module tb_pcm_fsk_transmitter;
  logic clk = 0;
  logic reset = 1;
  int n_checks = 0;
  int n_fail = 0;
  pcm_fsk_transmitter_if bus();
  pcm_fsk_transmitter #(.BIT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_log(input logic [12:0] d);
    logic [11:0] v;
    logic [2:0] s;
    logic [3:0] q;
    v = d[11:0];
    if (v < 32) begin s = 0; q = v[4:1]; end
    else if (v < 64) begin s = 1; q = v[4:1]; end
    else if (v < 128) begin s = 2; q = v[5:2]; end
    else if (v < 256) begin s = 3; q = v[6:3]; end
    else if (v < 512) begin s = 4; q = v[7:4]; end
    else if (v < 1024) begin s = 5; q = v[8:5]; end
    else if (v < 2048) begin s = 6; q = v[9:6]; end
    else begin s = 7; q = v[10:7]; end
    return {d[12], s, q};
  endfunction

  // Checks ncyc cycles of a frame carrying w, starting #1 after its load edge; datain becomes nd at cycle chg
  task automatic check_frame(input string name, input logic [8:0] w, input logic [12:0] nd, input int chg, input int ncyc);
    logic exp;
    logic [3:0] p;
    int errs;
    errs = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == chg) bus.datain = nd;
      p = 4'(c % 16);
      exp = w[8 - c / 16] ? p[1] : p[2];
      n_checks++;
      if (bus.fskdata !== exp) begin
        n_fail++;
        if (errs++ < 4) $display("FAIL %s cycle %0d: fskdata=%b required %b", name, c, bus.fskdata, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    bus.datain = 13'h001F;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.fskdata !== 1'b0) begin n_fail++; $display("FAIL reset_fsk: fskdata=%b required 0", bus.fskdata); end
    end
    n_checks++;
    if (bus.checked !== 9'h01E) begin n_fail++; $display("FAIL reset_checked: %h required 01e", bus.checked); end
  endtask

  task automatic test_vectors;
    logic [12:0] din [4] = '{13'h001F, 13'h0FFF, 13'h1040, 13'h1000};
    logic [7:0] lg [4] = '{8'h0F, 8'h7F, 8'hA0, 8'h80};
    logic [8:0] ck [4] = '{9'h01E, 9'h0FF, 9'h140, 9'h101};
    for (int i = 0; i < 4; i++) begin
      bus.datain = din[i]; #1;
      n_checks += 2;
      if (bus.pcmlog !== lg[i]) begin n_fail++; $display("FAIL vec_pcmlog %h: %h required %h", din[i], bus.pcmlog, lg[i]); end
      if (bus.checked !== ck[i]) begin n_fail++; $display("FAIL vec_checked %h: %h required %h", din[i], bus.checked, ck[i]); end
    end
  endtask

  task automatic test_sweep;
    logic [7:0] e;
    int errs;
    errs = 0;
    for (int i = 0; i < 8192; i++) begin
      bus.datain = 13'(i); #1;
      e = ref_log(13'(i));
      n_checks++;
      if (bus.pcmlog !== e || bus.checked !== {e, ^e}) begin
        n_fail++;
        if (errs++ < 8) $display("FAIL sweep %h: pcmlog=%h checked=%h required %h %h", i, bus.pcmlog, bus.checked, e, {e, ^e});
      end
    end
    for (int s = 1; s < 8; s++) begin
      bus.datain = 13'((16 << s) - 1); #1;
      e = bus.pcmlog;
      bus.datain = 13'(16 << s); #1;
      n_checks++;
      if (bus.pcmlog[6:4] !== e[6:4] + 3'd1 || bus.pcmlog[3:0] !== 4'd0 || e[3:0] !== 4'hF) begin
        n_fail++;
        $display("FAIL boundary %0d: below=%h above=%h", 16 << s, e, bus.pcmlog);
      end
    end
  endtask

  task automatic test_frames;
    bus.datain = 13'h001F;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    check_frame("frame_01e", 9'h01E, 13'h0FFF, 0, 144);
    check_frame("frame_0ff", 9'h0FF, 13'h1040, 0, 144);
    check_frame("frame_140", 9'h140, 13'h1000, 0, 144);
  endtask

  task automatic test_midframe;
    check_frame("mid_held", 9'h101, 13'h001F, 70, 144);
    check_frame("mid_next", 9'h01E, 13'h0FFF, 0, 144);
  endtask

  task automatic test_reset_mid;
    check_frame("pre_reset", 9'h0FF, 13'h0FFF, 999, 64);
    reset = 1;
    bus.datain = 13'h1040;
    repeat (5) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.fskdata !== 1'b0) begin n_fail++; $display("FAIL midreset_fsk: fskdata=%b required 0", bus.fskdata); end
    end
    reset = 0;
    @(posedge clk); #1;
    check_frame("post_reset", 9'h140, 13'h1000, 0, 144);
    check_frame("post_next", 9'h101, 13'h1000, 999, 144);
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_sweep;
    test_frames;
    test_midframe;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
